// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice with a registered carry walks the
// operands LSB first, then reports sum, carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_next;

  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = c_next;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // On the MSB, carry_q is the carry into the MSB and c_next the carry out.
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit and a 2-bit instance checked against an
// integer-arithmetic model of a+b+cin and signed overflow.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  // Returns {ovf, cout, sum} for a w-bit add, from plain integer arithmetic.
  function automatic int ref_add(int w, int av, int bv, int c);
    int total, s, co, sa, sb, st, ov;
    total = av + bv + c;
    s     = total % (1 << w);
    co    = total >> w;
    sa    = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb    = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    st    = sa + sb + c;
    ov    = (st > (1 << (w - 1)) - 1 || st < -(1 << (w - 1))) ? 1 : 0;
    return s | (co << w) | (ov << (w + 1));
  endfunction

  // Issues one operation from the current cycle and waits (bounded) for done.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic c,
                      output logic [9:0] res, output int lat, output int bn);
    a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; bn = 0;
    while (!done8 && lat < 32) begin
      if (busy8) bn++;
      @(posedge clk); #1;
      lat++;
    end
    res = {ovf8, cout8, sum8};
  endtask

  task automatic run2(input logic [1:0] av, input logic [1:0] bv, input logic c,
                      output logic [3:0] res, output int lat);
    a2 = av; b2 = bv; cin2 = c; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    lat = 0;
    while (!done2 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {ovf2, cout2, sum2};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy2, done2, sum2, cout2, ovf2} !== 5'd0) begin
      errors++;
      $display("FAIL reset2: got busy=%b done=%b sum=%h, expected all 0", busy2, done2, sum2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] av [3] = '{8'h3C, 8'hFF, 8'h80};
    logic [7:0] bv [3] = '{8'h5A, 8'h01, 8'h80};
    logic [9:0] want [3] = '{{1'b1, 1'b0, 8'h96}, {1'b0, 1'b1, 8'h00}, {1'b1, 1'b1, 8'h00}};
    logic [9:0] res;
    int lat, bn;
    for (int i = 0; i < 3; i++) begin
      run8(av[i], bv[i], 1'b0, res, lat, bn);
      checks++;
      if (res !== want[i] || lat != 8 || bn != 8) begin
        errors++;
        $display("FAIL directed%0d: got {ovf,cout,sum}=%h lat=%0d busy=%0d, expected %h lat=8 busy=8",
                 i, res, lat, bn, want[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL done_drop%0d: got done=%b busy=%b, expected 0 0", i, done8, busy8);
      end
      $display("op a=%h b=%h cin=0 -> sum=%h cout=%b ovf=%b", av[i], bv[i], res[7:0], res[8], res[9]);
    end
  endtask

  task automatic test_hold();
    logic [9:0] res;
    int lat, bn;
    run8(8'h00, 8'h00, 1'b1, res, lat, bn);
    checks++;
    if (res !== 10'h001) begin
      errors++;
      $display("FAIL cin_only: got %h, expected 001", res);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ovf8, cout8, sum8} !== 10'h001 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got %h done=%b, expected 001 done=0", i, {ovf8, cout8, sum8}, done8);
      end
    end
    $display("op a=00 b=00 cin=1 -> %h, held 5 cycles", res);
  endtask

  task automatic test_back_to_back();
    logic [9:0] res;
    logic [9:0] want;
    int lat;
    int bn;
    want = 10'(ref_add(8, 8'h25, 8'h4A, 1));
    a8 = 8'h25; b8 = 8'h4A; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 32) begin
      if (lat == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h11; cin8 = 1'b0; end
      if (lat == 4) start8 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({ovf8, cout8, sum8} !== want || lat != 8) begin
      errors++;
      $display("FAIL ignore_start: got %h lat=%0d, expected %h lat=8", {ovf8, cout8, sum8}, lat, want);
    end
    run8(8'h01, 8'h02, 1'b0, res, lat, bn);
    checks++;
    if (res !== 10'h003 || lat != 8) begin
      errors++;
      $display("FAIL start_in_done: got %h lat=%0d, expected 003 lat=8", res, lat);
    end
    $display("op ignored mid-run start, then back-to-back 01+02 -> %h", res);
  endtask

  task automatic test_abort();
    logic [9:0] res;
    int lat, bn;
    int seen;
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
      errors++;
      $display("FAIL abort: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles, expected 0", seen);
    end
    rst = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_start: got busy=%b, expected 0", busy8);
    end
    run8(8'h7F, 8'h01, 1'b0, res, lat, bn);
    checks++;
    if (res !== 10'h280 || lat != 8) begin
      errors++;
      $display("FAIL after_abort: got %h lat=%0d, expected 280 lat=8", res, lat);
    end
    $display("op aborted by rst, fresh 7F+01 -> %h", res);
  endtask

  task automatic test_random8();
    logic [7:0] av, bv;
    logic       c;
    logic [9:0] res, want;
    int lat, bn;
    for (int i = 0; i < 20; i++) begin
      av = 8'($urandom); bv = 8'($urandom); c = 1'($urandom);
      want = 10'(ref_add(8, int'(av), int'(bv), int'(c)));
      run8(av, bv, c, res, lat, bn);
      checks++;
      if (res !== want || lat != 8) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h cin=%b got %h lat=%0d, expected %h lat=8",
                 i, av, bv, c, res, lat, want);
      end
      $display("rand a=%h b=%h cin=%b -> %h", av, bv, c, res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w2_sweep();
    logic [3:0] res, want;
    logic [4:0] v;
    int lat;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      want = 4'(ref_add(2, int'(v[1:0]), int'(v[3:2]), int'(v[4])));
      run2(v[1:0], v[3:2], v[4], res, lat);
      checks++;
      if (res !== want || lat != 2) begin
        errors++;
        $display("FAIL w2_case%0d: got %h lat=%0d, expected %h lat=2", i, res, lat, want);
      end
      $display("w2 a=%0d b=%0d cin=%b -> {ovf,cout,sum}=%h", v[1:0], v[3:2], v[4], res);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_abort();
    test_random8();
    test_w2_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart of the team's combinational full-subtractor cell.
- Accepts two operands plus carry-in on a start pulse.
- Adds one bit per clock, LSB first, through a single full-adder slice with a registered carry.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulators in slow control paths.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse; sum/cout/ovf are valid.
- sum  output  WIDTH  result a+b+cin, mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- One clock, clk. rst is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, bit counter=0, internal carry=0.
- States and transitions:
  - IDLE: on an edge with start=1, latch a→shift reg A, b→shift reg B, cin→carry reg, counter←0, busy←1, state←RUN.
  - RUN: each edge performs the following:
    - s = A[0]^B[0]^carry; carry ← majority(A[0],B[0],carry).
    - Shift A and B right by one; shift s into sum from the MSB side (sum ← {s, sum[WIDTH-1:1]}).
    - counter++.
  - RUN exit: on the edge processing bit WIDTH-1:
    - cout ← final carry; ovf ← carry-in-to-MSB XOR final carry.
    - busy←0, done←1, state←IDLE.
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH. done is high for exactly the cycle after E_WIDTH, i.e. WIDTH cycles after busy rises.
- done deasserts on the next edge unconditionally.
- Result hold: sum/cout/ovf keep their values in IDLE until the next accepted start.
- During RUN, sum holds partial shifted data and is not valid. cout/ovf keep their previous values until the final bit.
- start while busy=1: ignored; the inputs a/b/cin are not resampled.
- start in the done cycle (state=IDLE, done=1): accepted. The new operation begins, giving back-to-back throughput of one result per WIDTH+1 cycles.
- Operand changes after the start edge have no effect on the operation in progress.
- rst mid-operation: abort immediately and return all outputs and state to their reset values. No done pulse is issued for the aborted operation.
- rst and start on the same edge: rst wins and start is dropped.
- Counter width: clog2(WIDTH)+1 bits; no wrap within one operation.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start one cycle → busy high 8 cycles, then done pulse 1 cycle, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- a=0x00, b=0x00, cin=1 → sum=0x01, cout=0, ovf=0. Results held unchanged for 5 idle cycles after done.
- start pulsed again at cycle 3 of RUN with a=0x11 → ignored; first result unchanged. Then start asserted in the done cycle with a=0x01, b=0x02 → accepted, next done gives sum=0x03.
- rst asserted at cycle 4 of RUN → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows; a fresh start then completes normally.
- WIDTH=2 build: exhaustive sweep of all a, b, cin (32 cases) against a reference model computing {cout,sum}=a+b+cin and signed overflow. Every case passes and the done-to-start spacing is 3 cycles.
